// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN_A = 2'b01,
        ST_OWN_B = 2'b10
    } state_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    // Encoding of the last-granted port
    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way picker: round-robin on ties, or A-first when FIXED_PRIO is set.
module rr_pick2
    import dmem_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic req_a,
    input  logic req_b,
    input  logic rr_last,
    output logic grant_a,
    output logic grant_b
);

    assign grant_a = req_a & (~req_b | FIXED_PRIO | (rr_last == RR_B));
    assign grant_b = req_b & ~grant_a;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between port A (CPU) and port B (loader DMA).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MAX_BURST  = 4,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [1:0]        owner
);

    localparam int unsigned          BURST_W    = $clog2(MAX_BURST) + 1;
    localparam logic [BURST_W-1:0]   BURST_LAST = BURST_W'(MAX_BURST - 1);

    state_e             state;
    logic [BURST_W-1:0] burst_cnt;
    logic               rr_last;
    logic               grant_a;
    logic               grant_b;
    logic               cur_req;
    logic               cur_lock;
    logic               other_req;
    logic               do_release;

    rr_pick2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req_a   (a_req),
        .req_b   (b_req),
        .rr_last (rr_last),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    // Owner-relative view of the request lines
    always_comb begin
        cur_req   = 1'b0;
        cur_lock  = 1'b0;
        other_req = 1'b0;
        case (state)
            ST_OWN_A: begin
                cur_req   = a_req;
                cur_lock  = a_lock;
                other_req = b_req;
            end
            ST_OWN_B: begin
                cur_req   = b_req;
                cur_lock  = b_lock;
                other_req = a_req;
            end
            default: ;
        endcase
        do_release = (state != ST_IDLE) &&
                     (!cur_req || !cur_lock || (burst_cnt == BURST_LAST));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            rr_last   <= RR_B;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_a)      state <= ST_OWN_A;
                    else if (grant_b) state <= ST_OWN_B;
                end
                ST_OWN_A, ST_OWN_B: begin
                    if (do_release) begin
                        burst_cnt <= '0;
                        rr_last   <= (state == ST_OWN_B) ? RR_B : RR_A;
                        // Hand over directly when the other port is already waiting
                        if (other_req) state <= (state == ST_OWN_A) ? ST_OWN_B : ST_OWN_A;
                        else           state <= ST_IDLE;
                    end else begin
                        burst_cnt <= burst_cnt + BURST_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory and handshake muxing follows the registered owner
    always_comb begin
        a_ack       = 1'b0;
        b_ack       = 1'b0;
        a_rdata     = '0;
        b_rdata     = '0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        owner       = OWN_NONE;
        case (state)
            ST_OWN_A: begin
                owner       = OWN_A;
                mem_addr    = a_addr;
                mem_data_in = a_wdata;
                mem_wr_en   = a_req & a_we;
                a_ack       = a_req;
                a_rdata     = mem_data_out;
            end
            ST_OWN_B: begin
                owner       = OWN_B;
                mem_addr    = b_addr;
                mem_data_in = b_wdata;
                mem_wr_en   = b_req & b_we;
                b_ack       = b_req;
                b_rdata     = mem_data_out;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: round-robin and fixed-priority instances vs a transfer-level model.
module tb_dmem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          a_req [2], a_we [2], a_lock [2], a_ack [2];
    logic          b_req [2], b_we [2], b_lock [2], b_ack [2];
    logic [AW-1:0] a_addr [2], b_addr [2], mem_addr [2];
    logic [DW-1:0] a_wdata [2], b_wdata [2], a_rdata [2], b_rdata [2];
    logic [DW-1:0] mem_data_in [2], mem_data_out [2];
    logic          mem_wr_en [2];
    logic [1:0]    owner [2];

    // Memory each DUT drives, plus the model's own copy
    logic [DW-1:0] bmem [2][64];
    logic [DW-1:0] rmem [2][64];
    logic          mem_init;

    int cur [2];   // 0 none, 1 A, 2 B
    int nb [2];    // transfers in current ownership
    int last [2];  // last port released
    bit pa [2], pb [2];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [DW-1:0] init_word(input int i, input int k);
        return DW'(k * 40503 + i * 4660 + 17);
    endfunction

    assign mem_data_out[0] = bmem[0][mem_addr[0][5:0]];
    assign mem_data_out[1] = bmem[1][mem_addr[1][5:0]];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_init) begin
                for (int k = 0; k < 64; k++) bmem[i][k] <= init_word(i, k);
            end else if (mem_wr_en[i]) begin
                bmem[i][mem_addr[i][5:0]] <= mem_data_in[i];
            end
        end
    end

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .FIXED_PRIO(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .a_req(a_req[0]), .a_we(a_we[0]), .a_lock(a_lock[0]), .a_addr(a_addr[0]),
        .a_wdata(a_wdata[0]), .a_ack(a_ack[0]), .a_rdata(a_rdata[0]),
        .b_req(b_req[0]), .b_we(b_we[0]), .b_lock(b_lock[0]), .b_addr(b_addr[0]),
        .b_wdata(b_wdata[0]), .b_ack(b_ack[0]), .b_rdata(b_rdata[0]),
        .mem_wr_en(mem_wr_en[0]), .mem_addr(mem_addr[0]), .mem_data_in(mem_data_in[0]),
        .mem_data_out(mem_data_out[0]), .owner(owner[0])
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .FIXED_PRIO(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req[1]), .a_we(a_we[1]), .a_lock(a_lock[1]), .a_addr(a_addr[1]),
        .a_wdata(a_wdata[1]), .a_ack(a_ack[1]), .a_rdata(a_rdata[1]),
        .b_req(b_req[1]), .b_we(b_we[1]), .b_lock(b_lock[1]), .b_addr(b_addr[1]),
        .b_wdata(b_wdata[1]), .b_ack(b_ack[1]), .b_rdata(b_rdata[1]),
        .mem_wr_en(mem_wr_en[1]), .mem_addr(mem_addr[1]), .mem_data_in(mem_data_in[1]),
        .mem_data_out(mem_data_out[1]), .owner(owner[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            a_req[i] = 0; a_we[i] = 0; a_lock[i] = 0; a_addr[i] = '0; a_wdata[i] = '0;
            b_req[i] = 0; b_we[i] = 0; b_lock[i] = 0; b_addr[i] = '0; b_wdata[i] = '0;
            pa[i] = 0; pb[i] = 0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            cur[i] = 0; nb[i] = 0; last[i] = 2;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_owner%0d", tag, i), 32'(owner[i]), 32'd0);
            chk($sformatf("%s_ack%0d", tag, i), 32'({a_ack[i], b_ack[i], mem_wr_en[i]}), 32'd0);
            chk($sformatf("%s_addr%0d", tag, i), 32'(mem_addr[i]), 32'd0);
            chk($sformatf("%s_din%0d", tag, i), 32'(mem_data_in[i]), 32'd0);
            chk($sformatf("%s_rdata%0d", tag, i), 32'({a_rdata[i], b_rdata[i]}), 32'd0);
        end
    endtask

    // Expected outputs follow directly from who owns the memory
    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            logic          ea, eb, ewe;
            logic [DW-1:0] ead, edin, ear, ebr;
            ea = 0; eb = 0; ewe = 0; ead = '0; edin = '0; ear = '0; ebr = '0;
            if (cur[i] == 1) begin
                ea = a_req[i]; ewe = a_req[i] & a_we[i]; ead = a_addr[i]; edin = a_wdata[i];
                ear = rmem[i][a_addr[i][5:0]];
            end else if (cur[i] == 2) begin
                eb = b_req[i]; ewe = b_req[i] & b_we[i]; ead = b_addr[i]; edin = b_wdata[i];
                ebr = rmem[i][b_addr[i][5:0]];
            end
            chk($sformatf("owner%0d", i), 32'(owner[i]), 32'(cur[i]));
            chk($sformatf("a_ack%0d", i), 32'(a_ack[i]), 32'(ea));
            chk($sformatf("b_ack%0d", i), 32'(b_ack[i]), 32'(eb));
            chk($sformatf("wr_en%0d", i), 32'(mem_wr_en[i]), 32'(ewe));
            chk($sformatf("addr%0d", i), 32'(mem_addr[i]), 32'(ead));
            chk($sformatf("din%0d", i), 32'(mem_data_in[i]), 32'(edin));
            chk($sformatf("a_rdata%0d", i), 32'(a_rdata[i]), 32'(ear));
            chk($sformatf("b_rdata%0d", i), 32'(b_rdata[i]), 32'(ebr));
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic step_model();
        for (int i = 0; i < 2; i++) begin
            if (cur[i] == 0) begin
                if (a_req[i] && b_req[i]) cur[i] = (i == 1 || last[i] == 2) ? 1 : 2;
                else if (a_req[i])        cur[i] = 1;
                else if (b_req[i])        cur[i] = 2;
            end else begin
                int            x;
                logic          rq, oth, lk, we;
                logic [DW-1:0] wd;
                logic [5:0]    ad;
                bit            rel;
                x   = cur[i];
                rq  = (x == 1) ? a_req[i] : b_req[i];
                oth = (x == 1) ? b_req[i] : a_req[i];
                lk  = (x == 1) ? a_lock[i] : b_lock[i];
                we  = (x == 1) ? a_we[i] : b_we[i];
                wd  = (x == 1) ? a_wdata[i] : b_wdata[i];
                ad  = (x == 1) ? a_addr[i][5:0] : b_addr[i][5:0];
                rel = 1;
                if (rq) begin
                    if (we) rmem[i][ad] = wd;
                    nb[i]++;
                    rel = !lk || (nb[i] == int'(MB));
                    if (x == 1) pa[i] = 0; else pb[i] = 0;
                end
                if (rel) begin
                    nb[i]   = 0;
                    last[i] = x;
                    cur[i]  = oth ? 3 - x : 0;
                end
            end
        end
    endtask

    task automatic tick();
        #2;
        check_outputs();
        @(posedge clk);
        step_model();
        @(negedge clk);
    endtask

    task automatic gen();
        for (int i = 0; i < 2; i++) begin
            if (!pa[i]) begin
                a_req[i] = ($urandom_range(0, 3) != 0);
                a_we[i] = 1'($urandom_range(0, 1));
                a_addr[i] = AW'($urandom_range(0, 15));
                a_wdata[i] = DW'($urandom);
                a_lock[i] = ($urandom_range(0, 2) != 0);
                pa[i] = a_req[i];
            end
            if (!pb[i]) begin
                b_req[i] = ($urandom_range(0, 3) != 0);
                b_we[i] = 1'($urandom_range(0, 1));
                b_addr[i] = AW'($urandom_range(0, 15));
                b_wdata[i] = DW'($urandom);
                b_lock[i] = ($urandom_range(0, 2) != 0);
                pb[i] = b_req[i];
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        mem_init = 1'b1;
        clear_inputs();
        model_reset();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 64; k++) rmem[i][k] = init_word(i, k);
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        mem_init = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Single A write, then B reads it back
        for (int i = 0; i < 2; i++) begin
            a_req[i] = 1; a_we[i] = 1; a_addr[i] = AW'(5); a_wdata[i] = DW'(16'h1234);
        end
        tick();
        chk("t1_owner", 32'(owner[0]), 32'd1);
        tick();
        for (int i = 0; i < 2; i++) a_req[i] = 0;
        tick();
        for (int i = 0; i < 2; i++) begin
            b_req[i] = 1; b_we[i] = 0; b_addr[i] = AW'(5);
        end
        tick();
        #1;
        chk("t1_b_rdata", 32'(b_rdata[0]), 32'h1234);
        chk("t1_b_ack", 32'(b_ack[0]), 32'd1);
        tick();
        for (int i = 0; i < 2; i++) b_req[i] = 0;
        tick();

        // Both ports requesting together: alternating ownership without gaps
        for (int i = 0; i < 2; i++) begin
            a_req[i] = 1; a_we[i] = 1; a_addr[i] = AW'(2); a_wdata[i] = DW'(16'h00A1);
            b_req[i] = 1; b_we[i] = 0; b_addr[i] = AW'(2);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("t2_alt%0d", k), 32'(owner[0]), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("t6_fix%0d", k), 32'(owner[1]), (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        clear_inputs();
        tick();
        tick();

        // Locked A burst against a waiting B, twice to show the count restarts
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 2; i++) begin
                a_req[i] = 1; a_we[i] = 0; a_lock[i] = 1; a_addr[i] = AW'(5 + r);
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                b_req[i] = 1; b_we[i] = 0; b_lock[i] = 0; b_addr[i] = AW'(7);
            end
            for (int k = 0; k < 4; k++) begin
                #1;
                chk($sformatf("t3_ack%0d_%0d", r, k), 32'(a_ack[0]), 32'd1);
                tick();
            end
            chk($sformatf("t3_owner%0d", r), 32'(owner[0]), 32'd2);
            for (int i = 0; i < 2; i++) a_req[i] = 0;
            tick();
            clear_inputs();
            tick();

            // Locked A drops its request after two transfers
            if (r == 0) begin
                for (int i = 0; i < 2; i++) begin
                    a_req[i] = 1; a_we[i] = 1; a_lock[i] = 1; a_addr[i] = AW'(3);
                    a_wdata[i] = DW'(16'h5A5A);
                end
                repeat (3) tick();
                for (int i = 0; i < 2; i++) a_req[i] = 0;
                tick();
                chk("t4_owner", 32'(owner[0]), 32'd0);
            end
        end

        // Reset asserted in the middle of a B write
        for (int i = 0; i < 2; i++) begin
            b_req[i] = 1; b_we[i] = 1; b_lock[i] = 1; b_addr[i] = AW'(9); b_wdata[i] = DW'(16'hBEEF);
        end
        tick();
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        clear_inputs();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk($sformatf("t5_word%0d", i), 32'(bmem[i][9]), 32'(rmem[i][9]));
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_req[i] = 1; b_req[i] = 1;
        end
        tick();
        chk("t5_tie_a", 32'(owner[0]), 32'd1);
        clear_inputs();
        tick();
        tick();

        // Randomized traffic with held requests
        for (int c = 0; c < 800; c++) begin
            gen();
            tick();
        end
        clear_inputs();
        repeat (3) tick();

        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 64; k++)
                chk($sformatf("mem%0d_%0d", i, k), 32'(bmem[i][k]), 32'(rmem[i][k]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
